// File: rtl/sfp_cage_ctrl_if.sv
// rtl/sfp_cage_ctrl_if.sv - SFP cage pin bundle between board pins and the cage controller
// master = board/pin side, slave = controller side.
interface sfp_cage_ctrl_if #(
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0] sfp_mod_abs;
  logic [N_PORTS-1:0] sfp_rxlos;
  logic [N_PORTS-1:0] sfp_txflt;
  logic [N_PORTS-1:0] sfp_tx_dis;
  logic [N_PORTS-1:0] sfp_rs0;
  logic [N_PORTS-1:0] sfp_rs1;

  modport master (
    output sfp_mod_abs, sfp_rxlos, sfp_txflt,
    input  sfp_tx_dis, sfp_rs0, sfp_rs1
  );

  modport slave (
    input  sfp_mod_abs, sfp_rxlos, sfp_txflt,
    output sfp_tx_dis, sfp_rs0, sfp_rs1
  );
endinterface

// File: rtl/sfp_cage_ctrl.sv
// rtl/sfp_cage_ctrl.sv - per-port SFP cage management: pin sync/debounce, TX enable sequencing, fault retry/lockout
// Optional status LEDs are built when SFP_LED_STATUS_EN is defined.
module sfp_cage_ctrl #(
  parameter int N_PORTS      = 2,
  parameter int DEBOUNCE_CYC = 100000,
  parameter int SETTLE_CYC   = 10000000,
  parameter int RETRY_CYC    = 1000000,
  parameter int MAX_RETRIES  = 3
`ifdef SFP_LED_STATUS_EN
  ,
  parameter int CLK_HZ       = 100000000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  sfp_cage_ctrl_if.slave         sfp,
  input  logic [N_PORTS-1:0]     tx_en,
  input  logic [N_PORTS-1:0]     rate_hi,
  input  logic [N_PORTS-1:0]     clr_lockout,
  output logic [N_PORTS-1:0]     link_up,
  output logic [N_PORTS-1:0]     lockout,
  output logic                   lockout_irq,
  output logic [3*N_PORTS-1:0]   port_state
`ifdef SFP_LED_STATUS_EN
  ,
  output logic [N_PORTS-1:0]     led
`endif
);

  localparam int TMR_MAX = (SETTLE_CYC > RETRY_CYC) ? SETTLE_CYC : RETRY_CYC;
  localparam int TMR_W   = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
  localparam int RTY_W   = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int DB_W    = ($clog2(DEBOUNCE_CYC + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam int NS      = 3 * N_PORTS;

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] RETRY_LD  = TMR_W'(RETRY_CYC - 1);
  localparam logic [RTY_W-1:0] MAX_R     = RTY_W'(MAX_RETRIES);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  // Debounced vector layout {fault, los, mod_abs}, held in raw pin polarity.
  localparam logic [NS-1:0]    DB_RST    = {{N_PORTS{1'b0}}, {N_PORTS{1'b1}}, {N_PORTS{1'b1}}};

  typedef enum logic [2:0] {
    ST_ABSENT  = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_FAULT   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  logic [N_PORTS-1:0] abs_s1_q, abs_s2_q;
  logic [N_PORTS-1:0] los_s1_q, los_s2_q;
  logic [N_PORTS-1:0] flt_s1_q, flt_s2_q;
  logic [N_PORTS-1:0] tx_en_q;
  logic [N_PORTS-1:0] rate_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_s1_q <= '1;
      abs_s2_q <= '1;
      los_s1_q <= '1;
      los_s2_q <= '1;
      flt_s1_q <= '0;
      flt_s2_q <= '0;
      tx_en_q  <= '0;
      rate_q   <= '0;
    end else begin
      abs_s1_q <= sfp.sfp_mod_abs;
      abs_s2_q <= abs_s1_q;
      los_s1_q <= sfp.sfp_rxlos;
      los_s2_q <= los_s1_q;
      flt_s1_q <= sfp.sfp_txflt;
      flt_s2_q <= flt_s1_q;
      tx_en_q  <= tx_en;
      rate_q   <= rate_hi;
    end
  end

  logic [NS-1:0]   sync_vec;
  logic [NS-1:0]   db_q;
  logic [DB_W-1:0] db_cnt_q [NS];

  assign sync_vec = {flt_s2_q, los_s2_q, abs_s2_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= DB_RST;
      for (int k = 0; k < NS; k++) db_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (sync_vec[k] == db_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          db_q[k]     <= sync_vec[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  logic [N_PORTS-1:0] present_db, los_db, fault_db;

  assign present_db = ~db_q[N_PORTS-1:0];
  assign los_db     = db_q[2*N_PORTS-1:N_PORTS];
  assign fault_db   = db_q[3*N_PORTS-1:2*N_PORTS];

  state_e             state_q  [N_PORTS];
  logic [TMR_W-1:0]   timer_q  [N_PORTS];
  logic [RTY_W-1:0]   retry_q  [N_PORTS];
  logic               irq_q;
  logic [N_PORTS-1:0] enter_lock;

  always_comb begin
    enter_lock = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      enter_lock[i] = present_db[i] && (state_q[i] == ST_ACTIVE) &&
                      fault_db[i] && (retry_q[i] == MAX_R);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        state_q[i] <= ST_ABSENT;
        timer_q[i] <= '0;
        retry_q[i] <= '0;
      end
    end else begin
      irq_q <= |enter_lock;
      for (int i = 0; i < N_PORTS; i++) begin
        // Module removal overrides every other transition, clr_lockout included.
        if (!present_db[i]) begin
          state_q[i] <= ST_ABSENT;
        end else begin
          case (state_q[i])
            ST_ABSENT: begin
              state_q[i] <= ST_SETTLE;
              timer_q[i] <= SETTLE_LD;
              retry_q[i] <= '0;
            end
            ST_SETTLE, ST_FAULT: begin
              if (timer_q[i] == '0) state_q[i] <= ST_ACTIVE;
              else                  timer_q[i] <= timer_q[i] - 1'b1;
            end
            ST_ACTIVE: begin
              if (fault_db[i]) begin
                if (retry_q[i] == MAX_R) begin
                  state_q[i] <= ST_LOCKOUT;
                end else begin
                  state_q[i] <= ST_FAULT;
                  retry_q[i] <= retry_q[i] + 1'b1;
                  timer_q[i] <= RETRY_LD;
                end
              end
            end
            ST_LOCKOUT: begin
              if (clr_lockout[i]) begin
                state_q[i] <= ST_SETTLE;
                timer_q[i] <= SETTLE_LD;
                retry_q[i] <= '0;
              end
            end
            default: state_q[i] <= ST_ABSENT;
          endcase
        end
      end
    end
  end

  logic [N_PORTS-1:0] tx_dis;

  always_comb begin
    tx_dis     = '1;
    link_up    = '0;
    lockout    = '0;
    port_state = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      port_state[3*i +: 3] = state_q[i];
      tx_dis[i]  = !((state_q[i] == ST_ACTIVE) && tx_en_q[i]);
      link_up[i] = (state_q[i] == ST_ACTIVE) && tx_en_q[i] && !los_db[i];
      lockout[i] = (state_q[i] == ST_LOCKOUT);
    end
  end

  assign sfp.sfp_tx_dis = tx_dis;
  assign sfp.sfp_rs0    = rate_q;
  assign sfp.sfp_rs1    = rate_q;
  assign lockout_irq    = irq_q;

`ifdef SFP_LED_STATUS_EN
  // Shared 16 Hz tick; phase_q counts sixteenths of a 1 s period.
  localparam int TICK_DIV = (CLK_HZ / 16 < 1) ? 1 : CLK_HZ / 16;
  localparam int PRE_W    = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]   pre_q;
  logic [3:0]         phase_q;
  logic [N_PORTS-1:0] led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      phase_q <= '0;
      led_q   <= '0;
    end else begin
      if (pre_q == PRE_LAST) begin
        pre_q   <= '0;
        phase_q <= phase_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      for (int i = 0; i < N_PORTS; i++) begin
        case (state_q[i])
          ST_SETTLE:           led_q[i] <= phase_q[2];
          ST_ACTIVE:           led_q[i] <= link_up[i] | phase_q[0];
          ST_FAULT, ST_LOCKOUT: led_q[i] <= (phase_q[3:1] == 3'd0);
          default:             led_q[i] <= 1'b0;
        endcase
      end
    end
  end

  assign led = led_q;
`endif

endmodule
